// File: rtl/pkg_cubos.sv
// Shared definitions for the falling-cube controller: FSM state encoding,
// default geometry/speed constants and small arithmetic helpers.
package pkg_cubos;

    // Controller states; two bits cover the whole fall cycle.
    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        CARGA    = 2'd1,
        CAIDA    = 2'd2,
        ATERRIZA = 2'd3
    } estado_t;

    // Default pixels per accepted frame tick.
    localparam int VELOCIDAD_DEF = 4;
    // Default floor row where the cube comes to rest.
    localparam int Y_PISO_DEF    = 448;
    // Default largest legal spawn column.
    localparam int X_MAX_DEF     = 480;

    // Landed-cube counter ceiling.
    localparam logic [7:0] CONT_MAX = 8'hFF;

    // Increment that sticks at the counter ceiling instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] valor);
        return (valor == CONT_MAX) ? valor : valor + 8'd1;
    endfunction

    // Clamp a requested column to the legal range.
    function automatic logic [8:0] clamp_x(input logic [8:0] x, input logic [8:0] limite);
        return (x > limite) ? limite : x;
    endfunction

endpackage

// File: rtl/control_caida_cubo.sv
// Falling-cube controller.
// A start request loads a spawn column and drops the cube by VELOCIDAD pixels
// on every frame tick that is not paused, until it reaches the floor row.
// Landing produces a one-cycle cubo_llego/pedir_nueva pulse and bumps a
// saturating landed-cube counter. All outputs come straight from registers.
// Build option: define CAIDA_AUTO_REINICIO_EN to respawn immediately after
// each landing instead of waiting for a new start request.
module control_caida_cubo
    import pkg_cubos::*;
#(
    parameter int VELOCIDAD = VELOCIDAD_DEF,
    parameter int Y_PISO    = Y_PISO_DEF,
    parameter int X_MAX     = X_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_frame,
    input  logic       iniciar,
    input  logic       pausa,
    input  logic [8:0] posicion_x,
    output logic [8:0] cubo_x,
    output logic [8:0] cubo_y,
    output logic       cubo_activo,
    output logic       cubo_llego,
    output logic       pedir_nueva,
    output logic [7:0] contador_cubos
);

    // Constants sized to the datapath they are compared against.
    localparam logic [9:0] VEL10   = 10'(VELOCIDAD);
    localparam logic [9:0] PISO10  = 10'(Y_PISO);
    localparam logic [8:0] PISO9   = 9'(Y_PISO);
    localparam logic [8:0] XMAX9   = 9'(X_MAX);

    estado_t    estado_q, estado_d;
    logic [8:0] cubo_x_q, cubo_x_d;
    logic [8:0] cubo_y_q, cubo_y_d;
    logic       activo_q, activo_d;
    logic       llego_q, llego_d;
    logic       pedir_q, pedir_d;
    logic [7:0] contador_q, contador_d;

    // Next row computed one bit wider so a step past the floor cannot wrap.
    logic [9:0] suma;

    // State and output registers, cleared immediately by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= REPOSO;
            cubo_x_q   <= '0;
            cubo_y_q   <= '0;
            activo_q   <= 1'b0;
            llego_q    <= 1'b0;
            pedir_q    <= 1'b0;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            cubo_x_q   <= cubo_x_d;
            cubo_y_q   <= cubo_y_d;
            activo_q   <= activo_d;
            llego_q    <= llego_d;
            pedir_q    <= pedir_d;
            contador_q <= contador_d;
        end
    end

    // Next-state and next-output logic; the landing pulse is produced on the
    // edge that enters ATERRIZA so it is visible exactly during that state.
    always_comb begin
        estado_d   = estado_q;
        cubo_x_d   = cubo_x_q;
        cubo_y_d   = cubo_y_q;
        activo_d   = activo_q;
        llego_d    = 1'b0;
        pedir_d    = 1'b0;
        contador_d = contador_q;
        suma       = {1'b0, cubo_y_q} + VEL10;

        case (estado_q)
            REPOSO: begin
                if (iniciar) begin
                    estado_d = CARGA;
                end
            end

            CARGA: begin
                cubo_x_d = clamp_x(posicion_x, XMAX9);
                cubo_y_d = '0;
                activo_d = 1'b1;
                estado_d = CAIDA;
            end

            CAIDA: begin
                // Paused ticks are dropped, not deferred.
                if (tick_frame && !pausa) begin
                    if (suma >= PISO10) begin
                        cubo_y_d   = PISO9;
                        activo_d   = 1'b0;
                        llego_d    = 1'b1;
                        pedir_d    = 1'b1;
                        contador_d = sat_inc8(contador_q);
                        estado_d   = ATERRIZA;
                    end else begin
                        cubo_y_d = suma[8:0];
                    end
                end
            end

            ATERRIZA: begin
`ifdef CAIDA_AUTO_REINICIO_EN
                estado_d = CARGA;
`else
                estado_d = REPOSO;
`endif
            end

            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    assign cubo_x         = cubo_x_q;
    assign cubo_y         = cubo_y_q;
    assign cubo_activo    = activo_q;
    assign cubo_llego     = llego_q;
    assign pedir_nueva    = pedir_q;
    assign contador_cubos = contador_q;

endmodule
